// File: rtl/dcache_data_array_ctrl.sv
// rtl/dcache_data_array_ctrl.sv - valid/ready front end for the dual-port dcache data SRAM macro.
// Optional build macro DCACHE_DATA_CONFLICT_STALL_EN holds off p1 reads of a line that p0 is writing.
module dcache_data_array_ctrl #(
    parameter int NUM_WMASKS = 32,
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [NUM_WMASKS-1:0] p0_req_wmask,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_resp_valid,
    input  logic                  p0_resp_ready,
    output logic [DATA_WIDTH-1:0] p0_resp_rdata,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    output logic                  p1_resp_valid,
    input  logic                  p1_resp_ready,
    output logic [DATA_WIDTH-1:0] p1_resp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    state_t                r_p0_state;
    state_t                r_p1_state;
    logic                  r_p0_resp_valid;
    logic                  r_p1_resp_valid;
    logic [DATA_WIDTH-1:0] r_p0_resp_rdata;
    logic [DATA_WIDTH-1:0] r_p1_resp_rdata;

    logic w_p0_ready;
    logic w_p1_ready_base;
    logic w_p1_ready;
    logic w_p1_conflict;
    logic w_p0_accept;
    logic w_p0_rd_accept;
    logic w_p0_wr_accept;
    logic w_p1_accept;

    // A port can take a new request when idle, or in the same cycle its pending response drains.
    assign w_p0_ready      = !rst && ((r_p0_state == ST_IDLE) ||
                                      ((r_p0_state == ST_RESP) && p0_resp_ready));
    assign w_p1_ready_base = !rst && ((r_p1_state == ST_IDLE) ||
                                      ((r_p1_state == ST_RESP) && p1_resp_ready));

    assign w_p0_accept    = p0_req_valid && w_p0_ready;
    assign w_p0_rd_accept = w_p0_accept && !p0_req_we;
    assign w_p0_wr_accept = w_p0_accept && p0_req_we;

`ifdef DCACHE_DATA_CONFLICT_STALL_EN
    logic                  r_wr_pend_q;
    logic [ADDR_WIDTH-1:0] r_wr_addr_q;

    // Covers both the write issuing now and the one the macro is still committing.
    assign w_p1_conflict = (w_p0_wr_accept && (p0_req_addr == p1_req_addr)) ||
                           (r_wr_pend_q && (r_wr_addr_q == p1_req_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_pend_q <= 1'b0;
            r_wr_addr_q <= '0;
        end else begin
            r_wr_pend_q <= w_p0_wr_accept;
            r_wr_addr_q <= p0_req_addr;
        end
    end
`else
    assign w_p1_conflict = 1'b0;
`endif

    assign w_p1_ready  = w_p1_ready_base && !w_p1_conflict;
    assign w_p1_accept = p1_req_valid && w_p1_ready;

    assign p0_req_ready  = w_p0_ready;
    assign p1_req_ready  = w_p1_ready;
    assign p0_resp_valid = r_p0_resp_valid;
    assign p1_resp_valid = r_p1_resp_valid;
    assign p0_resp_rdata = r_p0_resp_rdata;
    assign p1_resp_rdata = r_p1_resp_rdata;

    assign sram_csb0   = !w_p0_accept;
    assign sram_web0   = !w_p0_wr_accept;
    assign sram_wmask0 = p0_req_wmask;
    assign sram_addr0  = p0_req_addr;
    assign sram_din0   = p0_req_wdata;
    assign sram_csb1   = !w_p1_accept;
    assign sram_addr1  = p1_req_addr;

    // Writes are posted and never leave IDLE, so back-to-back writes stream one per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p0_state      <= ST_IDLE;
            r_p0_resp_valid <= 1'b0;
            r_p0_resp_rdata <= '0;
        end else begin
            case (r_p0_state)
                ST_IDLE: begin
                    if (w_p0_rd_accept) r_p0_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    r_p0_resp_rdata <= sram_dout0;
                    r_p0_resp_valid <= 1'b1;
                    r_p0_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (p0_resp_ready) begin
                        r_p0_resp_valid <= 1'b0;
                        r_p0_state      <= w_p0_rd_accept ? ST_RD_WAIT : ST_IDLE;
                    end
                end
                default: r_p0_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1_state      <= ST_IDLE;
            r_p1_resp_valid <= 1'b0;
            r_p1_resp_rdata <= '0;
        end else begin
            case (r_p1_state)
                ST_IDLE: begin
                    if (w_p1_accept) r_p1_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    r_p1_resp_rdata <= sram_dout1;
                    r_p1_resp_valid <= 1'b1;
                    r_p1_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (p1_resp_ready) begin
                        r_p1_resp_valid <= 1'b0;
                        r_p1_state      <= w_p1_accept ? ST_RD_WAIT : ST_IDLE;
                    end
                end
                default: r_p1_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_data_array_ctrl.sv
// tb/tb_dcache_data_array_ctrl.sv - scoreboard bench for dcache_data_array_ctrl with a behavioural SRAM.
module tb_dcache_data_array_ctrl;
    localparam int DW = 256;
    localparam int AW = 4;
    localparam int NM = 32;
    localparam logic [DW-1:0] IDLE_DOUT = {8{32'hDEADBEEF}};

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req_valid, p0_req_ready, p0_req_we;
    logic [AW-1:0] p0_req_addr;
    logic [NM-1:0] p0_req_wmask;
    logic [DW-1:0] p0_req_wdata;
    logic          p0_resp_valid, p0_resp_ready;
    logic [DW-1:0] p0_resp_rdata;
    logic          p1_req_valid, p1_req_ready;
    logic [AW-1:0] p1_req_addr;
    logic          p1_resp_valid, p1_resp_ready;
    logic [DW-1:0] p1_resp_rdata;
    logic          sram_csb0, sram_web0, sram_csb1;
    logic [NM-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0, sram_addr1;
    logic [DW-1:0] sram_din0, sram_dout0, sram_dout1;

    dcache_data_array_ctrl #(.NUM_WMASKS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wmask(p0_req_wmask), .p0_req_wdata(p0_req_wdata),
        .p0_resp_valid(p0_resp_valid), .p0_resp_ready(p0_resp_ready), .p0_resp_rdata(p0_resp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
        .p1_resp_valid(p1_resp_valid), .p1_resp_ready(p1_resp_ready), .p1_resp_rdata(p1_resp_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    always #5 clk = ~clk;

    // SRAM model: inputs sampled at posedge, dout driven to a junk pattern when not reading.
    logic [DW-1:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        sram_dout0 = IDLE_DOUT;
        sram_dout1 = IDLE_DOUT;
    end
    always @(posedge clk) begin
        sram_dout0 <= IDLE_DOUT;
        sram_dout1 <= IDLE_DOUT;
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
        if (!sram_csb0) begin
            if (sram_web0) sram_dout0 <= mem[sram_addr0];
            else begin
                for (int b = 0; b < NM; b++)
                    if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
            end
        end
    end

    int total = 0;
    int bad = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] e0, e1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (p0_resp_valid && p0_resp_ready) begin
                if (q0.size() == 0) chk1("p0_unexpected_resp", 1'b1, 1'b0);
                else begin
                    e0 = q0.pop_front();
                    chk("p0_rdata", p0_resp_rdata, e0);
                end
            end
            if (p1_resp_valid && p1_resp_ready) begin
                if (q1.size() == 0) chk1("p1_unexpected_resp", 1'b1, 1'b0);
                else begin
                    e1 = q1.pop_front();
                    chk("p1_rdata", p1_resp_rdata, e1);
                end
            end
        end
    end

    task automatic wait_p0();
        bit ok = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (p0_req_ready) begin ok = 1; break; end
        end
        if (!ok) chk1("p0_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_p1();
        bit ok = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (p1_req_ready) begin ok = 1; break; end
        end
        if (!ok) chk1("p1_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic p0_write(input logic [AW-1:0] a, input logic [NM-1:0] m, input logic [DW-1:0] d);
        p0_req_valid = 1; p0_req_we = 1; p0_req_addr = a; p0_req_wmask = m; p0_req_wdata = d;
        wait_p0();
        @(posedge clk); #1;
        p0_req_valid = 0; p0_req_we = 0;
    endtask

    task automatic p0_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
        p0_req_valid = 1; p0_req_we = 0; p0_req_addr = a;
        wait_p0();
        q0.push_back(e);
        @(posedge clk); #1;
        p0_req_valid = 0;
    endtask

    task automatic p1_read(input logic [AW-1:0] a, input logic [DW-1:0] e, input bit push);
        p1_req_valid = 1; p1_req_addr = a;
        wait_p1();
        if (push) q1.push_back(e);
        @(posedge clk); #1;
        p1_req_valid = 0;
    endtask

    initial begin
        rst = 1;
        p0_req_valid = 1; p0_req_we = 1; p0_req_addr = '0; p0_req_wmask = '0; p0_req_wdata = '0;
        p1_req_valid = 1; p1_req_addr = '0;
        p0_resp_ready = 1; p1_resp_ready = 1;

        // Reset holds everything quiet even with requests pending.
        repeat (3) @(negedge clk);
        chk1("rst_p0_ready", p0_req_ready, 1'b0);
        chk1("rst_p1_ready", p1_req_ready, 1'b0);
        chk1("rst_csb0", sram_csb0, 1'b1);
        chk1("rst_csb1", sram_csb1, 1'b1);
        chk1("rst_web0", sram_web0, 1'b1);
        chk1("rst_p0_resp_valid", p0_resp_valid, 1'b0);
        chk1("rst_p1_resp_valid", p1_resp_valid, 1'b0);
        chk("rst_p0_rdata", p0_resp_rdata, '0);
        @(posedge clk); #1;
        p0_req_valid = 0; p0_req_we = 0; p1_req_valid = 0;
        rst = 0;
        @(negedge clk);
        chk1("post_rst_p0_ready", p0_req_ready, 1'b1);
        chk1("post_rst_p1_ready", p1_req_ready, 1'b1);
        @(posedge clk); #1;

        // Masked write of the low word, then read back with latency check.
        p0_write(4'd3, 32'h0000000F, {8{32'hA5A5A5A5}});
        p0_read(4'd3, 256'hA5A5A5A5);
        @(negedge clk);
        chk1("lat_rd_wait", p0_resp_valid, 1'b0);
        @(negedge clk);
        chk1("lat_resp", p0_resp_valid, 1'b1);
        @(posedge clk); #1;

        // Streaming writes to every line, one per cycle.
        for (int i = 0; i < 16; i++) begin
            p0_req_valid = 1; p0_req_we = 1; p0_req_addr = AW'(i);
            p0_req_wmask = '1; p0_req_wdata = DW'(i);
            @(negedge clk);
            chk1("burst_wr_ready", p0_req_ready, 1'b1);
            @(posedge clk); #1;
        end
        p0_req_valid = 0; p0_req_we = 0;
        for (int i = 0; i < 16; i++) p0_read(AW'(i), DW'(i));
        repeat (3) @(posedge clk); #1;

        // Backpressure: response held while a new read waits.
        p0_resp_ready = 0;
        p0_read(4'd2, DW'(2));
        p0_req_valid = 1; p0_req_we = 0; p0_req_addr = 4'd7;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (p0_resp_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk1("bp_valid", p0_resp_valid, 1'b1);
            chk("bp_rdata_stable", p0_resp_rdata, DW'(2));
            chk1("bp_ready_low", p0_req_ready, 1'b0);
            chk1("bp_csb0_high", sram_csb0, 1'b1);
        end
        @(posedge clk); #1;
        p0_resp_ready = 1;
        q0.push_back(DW'(7));
        @(negedge clk);
        chk1("bp_release_ready", p0_req_ready, 1'b1);
        chk1("bp_release_csb0", sram_csb0, 1'b0);
        @(posedge clk); #1;
        p0_req_valid = 0;
        repeat (4) @(posedge clk); #1;

        // Same-line p0 write and p1 read in one cycle.
        p0_write(4'd5, '1, '0);
        @(posedge clk); #1;
        p0_req_valid = 1; p0_req_we = 1; p0_req_addr = 4'd5; p0_req_wmask = '1; p0_req_wdata = '1;
        p1_req_valid = 1; p1_req_addr = 4'd5;
`ifdef DCACHE_DATA_CONFLICT_STALL_EN
        q1.push_back('1);
        @(negedge clk);
        chk1("coll_p0_ready", p0_req_ready, 1'b1);
        chk1("coll_p1_stall0", p1_req_ready, 1'b0);
        @(posedge clk); #1;
        p0_req_valid = 0; p0_req_we = 0;
        @(negedge clk);
        chk1("coll_p1_stall1", p1_req_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("coll_p1_go", p1_req_ready, 1'b1);
        @(posedge clk); #1;
        p1_req_valid = 0;
`else
        q1.push_back('0);
        @(negedge clk);
        chk1("coll_p0_ready", p0_req_ready, 1'b1);
        chk1("coll_p1_ready", p1_req_ready, 1'b1);
        @(posedge clk); #1;
        p0_req_valid = 0; p0_req_we = 0; p1_req_valid = 0;
`endif
        repeat (4) @(posedge clk); #1;

        // Reset while p1 waits on the macro: that read is dropped.
        p1_read(4'd6, '0, 1'b0);
        rst = 1;
        @(negedge clk);
        chk1("abort_p1_ready", p1_req_ready, 1'b0);
        repeat (2) @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("abort_no_resp", p1_resp_valid, 1'b0);
        end
        @(posedge clk); #1;
        p1_read(4'd3, DW'(3), 1'b1);

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0) break;
        end
        chk1("queues_drained", (q0.size() == 0) && (q1.size() == 0), 1'b1);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
